i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS byte registers through a pointer/write-strobe/read-data port.
// Latency: SYNC_STAGES+1 clk from a pin edge to the resulting state/sda_oe update; wr_valid is a 1-clk pulse.
// Backpressure: none; the register file must accept wr_valid and present rd_data in the same clk.
module i2c_target_regs #(
  parameter int DEV_ADDR    = 7'h47,
  parameter int NUM_REGS    = 11,
  parameter int REG_AW      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  localparam logic [6:0]        DEV_A    = 7'(DEV_ADDR);
  localparam logic [8:0]        NREGS_W  = 9'(NUM_REGS);
  localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_REG_ADDR, S_ACK_REG,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_ACK_RD, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic                   bit_in, byte_done;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              mack_q, mack_d;
  logic              wr_valid_q, wr_valid_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  // Pointer advance with wrap; frozen when auto-increment is disabled.
  function automatic logic [REG_AW-1:0] ptr_next(input logic [REG_AW-1:0] p);
    if (AUTO_INC == 0) return p;
    if (p == LAST_REG) return '0;
    return p + REG_AW'(1);
  endfunction

  // Pin synchronizers plus one extra stage of history for edge detection; idle bus is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  // Bit count saturates at 8; the byte is acted on at the following SCL fall so sda_oe moves on a fall.
  assign bit_in    = scl_rise & (cnt_q != 4'd8);
  assign byte_done = scl_fall & (cnt_q == 4'd8);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      mack_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic: STOP beats START, both beat the per-state bit handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    mack_d     = mack_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (stop_det) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else if (start_det) begin
      state_d = S_DEV_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR: begin
          if (bit_in) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d = '0;
            if (shift_q[7:1] == DEV_A) begin
              state_d = S_ACK_DEV;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_ACK_DEV: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (shift_q[0]) begin
              state_d = S_RD_DATA;
              shift_d = rd_data;
              oe_d    = ~rd_data[7];
            end else begin
              state_d = S_REG_ADDR;
              oe_d    = 1'b0;
            end
          end
        end
        S_REG_ADDR: begin
          if (bit_in) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d = '0;
            if ({1'b0, shift_q} < NREGS_W) begin
              ptr_d   = shift_q[REG_AW-1:0];
              state_d = S_ACK_REG;
              oe_d    = 1'b1;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ACK_REG, S_ACK_WR: begin
          if (scl_fall) begin
            state_d = S_WR_DATA;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        S_WR_DATA: begin
          if (bit_in) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d      = '0;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_next(ptr_q);
            state_d    = S_ACK_WR;
            oe_d       = 1'b1;
          end
        end
        S_RD_DATA: begin
          if (bit_in) begin
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d   = '0;
            state_d = S_ACK_RD;
            oe_d    = 1'b0;
          end else if (scl_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        S_ACK_RD: begin
          // Advance on the 9th rise so rd_data already reflects the next register at the fall.
          if (scl_rise) begin
            mack_d = ~sda_s;
            ptr_d  = ptr_next(ptr_q);
          end else if (scl_fall) begin
            cnt_d = '0;
            if (mack_q) begin
              state_d = S_RD_DATA;
              shift_d = rd_data;
              oe_d    = ~rd_data[7];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, open-drain bus and a static register file.
// Directed vector table, hand-written multi-cycle sequences, then random transactions vs a model.
module tb_i2c_target_regs;
  localparam int Q  = 5;
  localparam int NR = 11;

  logic       clk = 1'b0;
  logic       rst, scl_drv, sda_drv;
  logic       scl_in, sda_in, sda_oe, wr_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  assign scl_in  = scl_drv;
  assign sda_in  = sda_drv & ~sda_oe;
  assign rd_data = mem[rd_addr];

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Bus monitor: log every write strobe cycle and count sda_oe / busy cycles.
  int          wr_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [11:0] wr_log [512];
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_log[wr_cnt] <= {wr_addr, wr_data};
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_c();
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic stop_c();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b1; wq(); wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_drv = b[7-i]; wq();
      scl_drv = 1'b1;   wq(); wq();
      scl_drv = 1'b0;   wq();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    ack = ~sda_in;  wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq();
      scl_drv = 1'b1; wq();
      b[i] = sda_in;  wq();
      scl_drv = 1'b0; wq();
    end
    sda_drv = ~mack; wq();
    scl_drv = 1'b1;  wq(); wq();
    scl_drv = 1'b0;  wq();
    sda_drv = 1'b1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] dev, rb, dat;
    logic       a_dev, a_reg, a_dat;
    int         nwr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] ptr;
  } vec_t;

  vec_t       vt [6];
  logic       a0, a1, a2;
  logic [7:0] rb8, db8, dev8;
  int         bw, bo, bb, model_ptr, n, kind;
  logic [3:0] exp_a [4];
  logic [7:0] exp_d [4];

  initial begin
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    vt[0] = '{8'h8E, 8'h03, 8'hA5, 1'b1, 1'b1, 1'b1, 1, 4'd3,  8'hA5, 4'd4};
    vt[1] = '{8'h90, 8'h03, 8'h55, 1'b0, 1'b0, 1'b0, 0, 4'd0,  8'h00, 4'd4};
    vt[2] = '{8'h8E, 8'h0C, 8'h77, 1'b1, 1'b0, 1'b0, 0, 4'd0,  8'h00, 4'd4};
    vt[3] = '{8'h8E, 8'h0A, 8'h3C, 1'b1, 1'b1, 1'b1, 1, 4'd10, 8'h3C, 4'd0};
    vt[4] = '{8'h8E, 8'h0B, 8'h00, 1'b1, 1'b0, 1'b0, 0, 4'd0,  8'h00, 4'd0};
    vt[5] = '{8'h8E, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1, 4'd0,  8'hFF, 4'd1};
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset sda_oe", sda_oe, 0);
    chk("reset wr_valid", wr_valid, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_addr", rd_addr, 0);

    // Directed single-byte write transactions.
    for (int i = 0; i < 6; i++) begin
      bw = wr_cnt; bo = oe_cnt; bb = busy_cnt;
      start_c();
      write_byte(vt[i].dev, a0);
      write_byte(vt[i].rb, a1);
      write_byte(vt[i].dat, a2);
      stop_c();
      chk($sformatf("v%0d ack_dev", i), a0, vt[i].a_dev);
      chk($sformatf("v%0d ack_reg", i), a1, vt[i].a_reg);
      chk($sformatf("v%0d ack_dat", i), a2, vt[i].a_dat);
      chk($sformatf("v%0d nwr", i), wr_cnt - bw, vt[i].nwr);
      if (vt[i].nwr == 1)
        chk($sformatf("v%0d wr addr/data", i), wr_log[bw], {vt[i].waddr, vt[i].wdata});
      chk($sformatf("v%0d rd_addr", i), rd_addr, vt[i].ptr);
      chk($sformatf("v%0d busy after stop", i), busy, 0);
      chk($sformatf("v%0d busy seen", i), busy_cnt != bb, vt[i].a_dev);
      chk($sformatf("v%0d sda_oe seen", i), oe_cnt != bo, vt[i].a_dev);
    end

    // Auto-increment wrap across the last register.
    bw = wr_cnt;
    start_c();
    write_byte(8'h8E, a0); write_byte(8'h09, a1);
    chk("wrap ack dev", a0, 1); chk("wrap ack reg", a1, 1);
    write_byte(8'h11, a0); write_byte(8'h22, a1); write_byte(8'h33, a2);
    stop_c();
    chk("wrap acks", {a0, a1, a2}, 3'b111);
    chk("wrap nwr", wr_cnt - bw, 3);
    chk("wrap w0", wr_log[bw], {4'd9, 8'h11});
    chk("wrap w1", wr_log[bw+1], {4'd10, 8'h22});
    chk("wrap w2", wr_log[bw+2], {4'd0, 8'h33});
    chk("wrap rd_addr", rd_addr, 1);

    // Set pointer, repeated START, read two bytes.
    mem[2] = 8'h5A; mem[3] = 8'hC3; mem[4] = 8'h6D;
    start_c();
    write_byte(8'h8E, a0); write_byte(8'h02, a1);
    start_c();
    write_byte(8'h8F, a2);
    chk("rs acks", {a0, a1, a2}, 3'b111);
    read_byte(1'b1, db8); chk("rs byte0", db8, 8'h5A);
    read_byte(1'b0, db8); chk("rs byte1", db8, 8'hC3);
    chk("rs busy mid", busy, 1);
    stop_c();
    chk("rs rd_addr", rd_addr, 4);
    chk("rs busy after stop", busy, 0);

    // Out-of-range register byte keeps the pointer; next read uses it.
    start_c();
    write_byte(8'h8E, a0); write_byte(8'h0C, a1);
    stop_c();
    chk("nack reg ack dev", a0, 1);
    chk("nack reg ack reg", a1, 0);
    chk("nack reg rd_addr", rd_addr, 4);
    start_c();
    write_byte(8'h8F, a0);
    read_byte(1'b0, db8);
    stop_c();
    chk("retained ptr read", db8, 8'h6D);
    chk("retained ptr after", rd_addr, 5);

    // Reset mid data byte, then STOP at bit 4 of a fresh write.
    bw = wr_cnt;
    start_c();
    write_byte(8'h8E, a0); write_byte(8'h07, a1);
    send_bits(8'hF0, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst wr_valid", wr_valid, 0);
    chk("rst rd_addr", rd_addr, 0);
    rst = 1'b0;
    send_bits(8'h0F, 4);
    stop_c();
    start_c();
    write_byte(8'h8E, a0); write_byte(8'h01, a1);
    send_bits(8'hAB, 4);
    stop_c();
    chk("partial acks", {a0, a1}, 2'b11);
    chk("partial nwr", wr_cnt - bw, 0);
    chk("partial rd_addr", rd_addr, 1);
    chk("partial busy", busy, 0);

    // Random transactions against a behavioural model.
    pulse_rst();
    model_ptr = 0;
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 2);
      bw = wr_cnt; bb = busy_cnt;
      start_c();
      if (kind == 0) begin
        rb8 = 8'($urandom_range(0, 15));
        n = $urandom_range(0, 3);
        write_byte(8'h8E, a0); chk($sformatf("r%0d w ack dev", t), a0, 1);
        write_byte(rb8, a1);   chk($sformatf("r%0d w ack reg", t), a1, rb8 < NR);
        if (rb8 < NR) model_ptr = rb8;
        for (int k = 0; k < n; k++) begin
          db8 = 8'($urandom);
          write_byte(db8, a2);
          chk($sformatf("r%0d w ack d%0d", t, k), a2, rb8 < NR);
          exp_a[k] = 4'(model_ptr); exp_d[k] = db8;
          if (rb8 < NR) model_ptr = (model_ptr + 1) % NR;
        end
        stop_c();
        chk($sformatf("r%0d w nwr", t), wr_cnt - bw, (rb8 < NR) ? n : 0);
        if (rb8 < NR)
          for (int k = 0; k < n; k++)
            chk($sformatf("r%0d w entry%0d", t, k), wr_log[bw+k], {exp_a[k], exp_d[k]});
      end else if (kind == 1) begin
        n = $urandom_range(1, 3);
        write_byte(8'h8F, a0); chk($sformatf("r%0d r ack dev", t), a0, 1);
        for (int k = 0; k < n; k++) begin
          read_byte(k != n - 1, db8);
          chk($sformatf("r%0d r byte%0d", t, k), db8, mem[model_ptr]);
          model_ptr = (model_ptr + 1) % NR;
        end
        stop_c();
        chk($sformatf("r%0d r nwr", t), wr_cnt - bw, 0);
      end else begin
        do dev8 = 8'($urandom); while (dev8[7:1] == 7'h47);
        write_byte(dev8, a0);
        write_byte(8'($urandom), a1);
        stop_c();
        chk($sformatf("r%0d x acks", t), {a0, a1}, 2'b00);
        chk($sformatf("r%0d x busy seen", t), busy_cnt != bb, 0);
        chk($sformatf("r%0d x nwr", t), wr_cnt - bw, 0);
      end
      chk($sformatf("r%0d rd_addr", t), rd_addr, model_ptr);
      chk($sformatf("r%0d busy", t), busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
